share_result_queue: RTL and testbench

//  Sits directly downstream of dsha_finisher and upstream of uart_multibyte_transmitter.
//  - Qualifies each finished double-SHA result against a leading-zero difficulty target.
//  - Drops duplicates and buffers qualifying (hash, nonce) pairs in a small FIFO.
//  - Presents one framed 512-bit message at a time to the UART with a valid/ready handshake.
//  - Each share is sent exactly once, instead of req staying high while the hash stays low.

---
 rtl/share_result_queue_pkg.sv | 27 ++
 rtl/share_result_queue_sync_fifo.sv | 67 ++++++
 rtl/share_result_queue.sv | 122 ++++++++++++
 tb/tb_share_result_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/share_result_queue_pkg.sv
// Shared mining constants, the queued share record and the UART framing helper.
package share_result_queue_pkg;

    localparam int unsigned HASH_W  = 256;
    localparam int unsigned NONCE_W = 32;
    localparam int unsigned MSG_W   = 512;

    localparam logic [7:0]  FRAME_SEP    = 8'hAA;
    localparam logic [63:0] FRAME_MARKER = 64'hDEAD432987BEEFAA;

    // Zero gap between the second separator and the trailing marker.
    localparam int unsigned FRAME_PAD_W = MSG_W - 64 - 8 - NONCE_W - 8 - HASH_W;

    // One queued share; nonce sits above hash so the packed form is {nonce, hash}.
    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [HASH_W-1:0]  hash;
    } share_t;

    localparam int unsigned SHARE_W = $bits(share_t);

    // Build the 512-bit UART message for one share.
    function automatic logic [MSG_W-1:0] frame_share(share_t s);
        return {FRAME_MARKER, {FRAME_PAD_W{1'b0}}, FRAME_SEP, s.nonce, FRAME_SEP, s.hash};
    endfunction

endpackage

// File: rtl/share_result_queue_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers and a synchronous active-low reset.
// A pop and a push in the same cycle both succeed, even when the FIFO is full.
module share_result_queue_sync_fifo #(
    parameter int unsigned WIDTH     = 288,
    parameter int unsigned DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   level
);

    localparam int unsigned Depth = 1 << DEPTH_LOG;

    logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [Depth];
    logic               pop_en;
    logic               push_en;

    // Status flags and qualified push/pop; a pop frees the slot a full-cycle push needs.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[DEPTH_LOG] != rd_ptr_q[DEPTH_LOG]) &&
                  (wr_ptr_q[DEPTH_LOG-1:0] == rd_ptr_q[DEPTH_LOG-1:0]);
        level   = wr_ptr_q - rd_ptr_q;
        pop_en  = pop & ~empty;
        push_en = push & (~full | pop_en);
        rdata   = mem_q[rd_ptr_q[DEPTH_LOG-1:0]];
    end

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/share_result_queue.sv
// Qualifies finished double-SHA results against a leading-zero target, drops repeats of the
// last accepted nonce, queues shares and hands them to the UART one framed message at a time.
module share_result_queue
    import share_result_queue_pkg::*;
#(
    parameter int unsigned ZERO_BITS = 32,
    parameter int unsigned DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [HASH_W-1:0]    hash,
    input  logic [NONCE_W-1:0]   in_nonce,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [MSG_W-1:0]     tx_data,
    output logic [31:0]          share_count,
    output logic [15:0]          drop_count,
    output logic [DEPTH_LOG:0]   fifo_level
);

    // Stage 1 registers.
    logic [HASH_W-1:0]  h1_q;
    logic [NONCE_W-1:0] n1_q;
    logic               hit1_q;
    logic               hit_now;

    // Dedup and counters.
    logic [NONCE_W-1:0] last_nonce_q, last_nonce_d;
    logic               last_valid_q, last_valid_d;
    logic [31:0]        share_count_q, share_count_d;
    logic [15:0]        drop_count_q, drop_count_d;

    logic               accept;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    share_t             push_share;
    share_t             head_share;

    // Leading-zero qualification on the raw input.
    always_comb begin
        hit_now = in_valid & (hash[HASH_W-1 -: ZERO_BITS] == '0);
    end

    // Stage 1: capture the candidate and whether it meets the target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h1_q   <= '0;
            n1_q   <= '0;
            hit1_q <= 1'b0;
        end else begin
            h1_q   <= hash;
            n1_q   <= in_nonce;
            hit1_q <= hit_now;
        end
    end

    // Stage 2: dedup against the last accepted nonce, then count accepts and overflow drops.
    // A full FIFO that is popping this cycle still takes the push, so that is not a drop.
    always_comb begin
        accept        = hit1_q & ~(last_valid_q & (n1_q == last_nonce_q));
        drop          = accept & fifo_full & ~tx_ready;
        last_nonce_d  = last_nonce_q;
        last_valid_d  = last_valid_q;
        share_count_d = share_count_q;
        drop_count_d  = drop_count_q;
        if (accept) begin
            last_nonce_d  = n1_q;
            last_valid_d  = 1'b1;
            share_count_d = share_count_q + 32'd1;
        end
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // Dedup state and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_nonce_q  <= '0;
            last_valid_q  <= 1'b0;
            share_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            last_nonce_q  <= last_nonce_d;
            last_valid_q  <= last_valid_d;
            share_count_q <= share_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    // Queue entry assembled from the stage-1 registers.
    always_comb begin
        push_share.nonce = n1_q;
        push_share.hash  = h1_q;
    end

    share_result_queue_sync_fifo #(
        .WIDTH     (SHARE_W),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (push_share),
        .pop   (tx_ready),
        .rdata (head_share),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Output side: head of queue framed for the UART, valid whenever anything is queued.
    always_comb begin
        tx_valid    = ~fifo_empty;
        tx_data     = frame_share(head_share);
        share_count = share_count_q;
        drop_count  = drop_count_q;
    end

endmodule

// File: tb/tb_share_result_queue.sv
// Directed bench with a share scoreboard: shares expected to enter the queue are pushed
// when driven and compared against tx_data at each handshake.
module tb_share_result_queue;

    localparam int unsigned ZERO_BITS = 32;
    localparam int unsigned DEPTH_LOG = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [255:0] hash;
    logic [31:0]  in_nonce;
    logic         tx_valid;
    logic         tx_ready;
    logic [511:0] tx_data;
    logic [31:0]  share_count;
    logic [15:0]  drop_count;
    logic [DEPTH_LOG:0] fifo_level;

    int errors = 0;
    int checks = 0;

    logic [287:0] exp_q [$];

    share_result_queue #(
        .ZERO_BITS (ZERO_BITS),
        .DEPTH_LOG (DEPTH_LOG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .hash        (hash),
        .in_nonce    (in_nonce),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .share_count (share_count),
        .drop_count  (drop_count),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] frame(logic [31:0] n, logic [255:0] h);
        return {64'hDEAD432987BEEFAA, 144'h0, 8'hAA, n, 8'hAA, h};
    endfunction

    function automatic logic [255:0] mk_hash(int unsigned s);
        logic [31:0] w;
        w = s * 32'h9E3779B9 + 32'h0BADF00D;
        return {32'h0, {7{w}}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: at the negedge, score any handshake about to happen; return 1 after posedge.
    task automatic tick();
        logic [287:0] e;
        @(negedge clk);
        if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL pop_unexpected: observed %0h expected no share", tx_data);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", tx_data, frame(e[287:256], e[255:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tx_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Single-cycle strobe; optionally recorded as an expected queue entry.
    task automatic strobe(input logic [255:0] h, input logic [31:0] n, input bit expect_push);
        in_valid = 1'b1;
        hash     = h;
        in_nonce = n;
        if (expect_push) exp_q.push_back({n, h});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 512'(tx_valid), 512'(1));
            tick();
        end
        tx_ready = 1'b0;
        chk({tag, "_empty"}, 512'(fifo_level), 512'(0));
        chk({tag, "_sb_left"}, 512'(exp_q.size()), 512'(0));
    endtask

    initial begin
        logic [255:0] h_t1;
        h_t1     = 256'h00000000_12345678_9abcdef0_0fedcba9_87654321_13579bdf_2468ace0_a5a5a5a5;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tx_ready = 1'b0;
        hash     = '0;
        in_nonce = '0;
        tick();
        do_reset();

        // Reset state
        chk("rst_valid", 512'(tx_valid), 512'(0));
        chk("rst_level", 512'(fifo_level), 512'(0));
        chk("rst_share", 512'(share_count), 512'(0));
        chk("rst_drop", 512'(drop_count), 512'(0));

        // 1: first share, two-cycle latency, no bypass
        strobe(h_t1, 32'hB2957C03, 1'b1);
        chk("t1_no_bypass", 512'(tx_valid), 512'(0));
        tick();
        chk("t1_valid", 512'(tx_valid), 512'(1));
        chk("t1_nonce", 512'(tx_data[295:264]), 512'(32'hB2957C03));
        chk("t1_marker", 512'(tx_data[511:448]), 512'(64'hDEAD432987BEEFAA));
        chk("t1_frame", tx_data, frame(32'hB2957C03, h_t1));
        chk("t1_share", 512'(share_count), 512'(1));
        tick();
        chk("t1_stable", tx_data, frame(32'hB2957C03, h_t1));
        drain(1, "t1_drain");

        // 2: one bit short of the target
        strobe({32'h00000001, 224'h1}, 32'h0000C0DE, 1'b0);
        tick();
        tick();
        chk("t2_valid", 512'(tx_valid), 512'(0));
        chk("t2_share", 512'(share_count), 512'(1));
        chk("t2_level", 512'(fifo_level), 512'(0));

        // 3: the same nonce held for four strobes
        do_reset();
        in_valid = 1'b1;
        hash     = mk_hash(77);
        in_nonce = 32'h11111111;
        exp_q.push_back({32'h11111111, mk_hash(77)});
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t3_level", 512'(fifo_level), 512'(1));
        chk("t3_share", 512'(share_count), 512'(1));
        drain(1, "t3_drain");

        // 4: ten distinct hits into an eight-entry queue with the transmitter busy
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            hash     = mk_hash(i);
            in_nonce = 32'h40000000 + 32'(i);
            if (i < 8) exp_q.push_back({in_nonce, hash});
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("t4_level", 512'(fifo_level), 512'(8));
        chk("t4_drop", 512'(drop_count), 512'(2));
        drain(8, "t4_drain");
        chk("t4_drop_kept", 512'(drop_count), 512'(2));

        // tx_ready while empty is ignored
        tx_ready = 1'b1;
        tick();
        tick();
        chk("idle_level", 512'(fifo_level), 512'(0));
        chk("idle_valid", 512'(tx_valid), 512'(0));
        tx_ready = 1'b0;

        // 5: full queue, a hit lands on the same edge as a pop
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            hash     = mk_hash(100 + i);
            in_nonce = 32'h50000000 + 32'(i);
            exp_q.push_back({in_nonce, hash});
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("t5_full", 512'(fifo_level), 512'(8));
        strobe(mk_hash(200), 32'h500000FF, 1'b1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("t5_level", 512'(fifo_level), 512'(8));
        chk("t5_drop", 512'(drop_count), 512'(2));
        drain(8, "t5_drain");

        // 6: reset with three shares queued discards them; the last nonce is accepted again
        for (int i = 0; i < 3; i++) begin
            strobe(mk_hash(300 + i), 32'h60000000 + 32'(i), 1'b1);
        end
        tick();
        tick();
        chk("t6_pre_level", 512'(fifo_level), 512'(3));
        do_reset();
        chk("t6_valid", 512'(tx_valid), 512'(0));
        chk("t6_level", 512'(fifo_level), 512'(0));
        chk("t6_share", 512'(share_count), 512'(0));
        chk("t6_drop", 512'(drop_count), 512'(0));
        strobe(mk_hash(302), 32'h60000002, 1'b1);
        tick();
        chk("t6_again_share", 512'(share_count), 512'(1));
        chk("t6_again_frame", tx_data, frame(32'h60000002, mk_hash(302)));
        drain(1, "t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
